// File: rtl/alu_sequencer.sv
// Multi-cycle signed add/sub/mul/div sequencer for the calculator datapath.
// Shift-add multiply and restoring divide run one bit per clock.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_in,
  input  logic             execute,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err_ovf,
  output logic             err_div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SIGN,
    DONE
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sa;
  logic               sb;
  logic               dz;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               b_zero;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   as_sum;
  logic               as_ovf;
  logic [2*WIDTH-1:0] md_mag;
  logic [2*WIDTH-1:0] lim_p;
  logic               md_neg;
  logic               md_ovf;
  logic [WIDTH-1:0]   md_res;

  assign abs_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign b_zero = (operand_b == '0);

  // acc = {high partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, mag_a} : '0);

  // acc = {remainder, dividend bits shifting out / quotient shifting in}
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_rem   = div_shift[WIDTH-1:0] - mag_b;

  assign b_eff  = op_q[0] ? ~b_q : b_q;
  assign as_sum = a_q + b_eff + WIDTH'(op_q[0]);
  assign as_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1])
               && (as_sum[WIDTH-1] != a_q[WIDTH-1]);

  assign md_mag = op_q[0] ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
  assign lim_p  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  assign md_neg = (sa ^ sb) && (md_mag != '0);
  assign md_ovf = md_neg ? (md_mag > lim_p + 1'b1) : (md_mag > lim_p);
  assign md_res = md_neg ? -md_mag[WIDTH-1:0] : md_mag[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err_ovf  <= 1'b0;
      err_div0 <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (execute) begin
            op_q     <= op;
            a_q      <= operand_a;
            b_q      <= operand_b;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            sa       <= operand_a[WIDTH-1];
            sb       <= operand_b[WIDTH-1];
            dz       <= (op == 2'b11) && b_zero;
            result   <= '0;
            err_ovf  <= 1'b0;
            err_div0 <= 1'b0;
            busy     <= 1'b1;
            if (op[1] && !(op[0] && b_zero)) begin
              cnt   <= CW'(WIDTH);
              acc   <= {{WIDTH{1'b0}}, op[0] ? abs_a : abs_b};
              state <= ITER;
            end else begin
              state <= SIGN;
            end
          end
        end
        ITER: begin
          if (!op_q[0]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else if (div_ge) begin
            acc <= {div_rem, acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= SIGN;
        end
        SIGN: begin
          if (dz) begin
            result   <= '0;
            err_div0 <= 1'b1;
            err_ovf  <= 1'b0;
          end else if (op_q[1]) begin
            result  <= md_res;
            err_ovf <= md_ovf;
          end else begin
            result  <= as_sum;
            err_ovf <= as_ovf;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (WIDTH=16).
// Each task drives one scenario and checks its own expectations.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset_in = 1'b1;
  logic        execute = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        err_ovf;
  logic        err_div0;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset_in  (reset_in),
    .execute   (execute),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err_ovf   (err_ovf),
    .err_div0  (err_div0)
  );

  always #5 clock = ~clock;

  // Leaves time at E0 + 1.
  task automatic accept(input logic [1:0] o,
                        input logic [15:0] a,
                        input logic [15:0] b);
    @(negedge clock);
    op = o;
    operand_a = a;
    operand_b = b;
    execute = 1'b1;
    @(posedge clock);
    #1;
    execute = 1'b0;
  endtask

  // Returns k such that done is sampled high at edge Ek (0 on timeout).
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        k = i + 1;
        break;
      end
    end
  endtask

  task automatic leave_done();
    @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, err_ovf, err_div0, result} !== 20'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b ovf=%b dz=%b res=%h want all 0",
               busy, done, err_ovf, err_div0, result);
    end
    @(negedge clock);
    reset_in = 1'b0;
  endtask

  task automatic test_add();
    int k;
    accept(2'b00, 16'd100, -16'sd250);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL add_busy: busy=%b want 1", busy);
    end
    wait_done(k);
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL add_latency: done at E%0d want E2", k);
    end
    checks++;
    if (result !== 16'hFF6A || err_ovf !== 1'b0 || err_div0 !== 1'b0) begin
      errors++;
      $display("FAIL add_result: res=%h ovf=%b dz=%b want ff6a 0 0",
               result, err_ovf, err_div0);
    end
    leave_done();
    accept(2'b00, 16'h7FFF, 16'h0001);
    wait_done(k);
    checks++;
    if (result !== 16'h8000 || err_ovf !== 1'b1 || k != 2) begin
      errors++;
      $display("FAIL add_ovf: res=%h ovf=%b k=%0d want 8000 1 2",
               result, err_ovf, k);
    end
    leave_done();
  endtask

  task automatic test_mul();
    int k;
    int low_busy;
    accept(2'b10, -16'sd123, 16'd45);
    k = 0;
    low_busy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (!busy) low_busy++;
      if (done) begin
        k = i + 1;
        break;
      end
    end
    checks++;
    if (k != 18 || low_busy != 0) begin
      errors++;
      $display("FAIL mul_timing: done at E%0d busy_low=%0d want E18 0",
               k, low_busy);
    end
    checks++;
    if (result !== 16'hEA61 || err_ovf !== 1'b0 || err_div0 !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: res=%h ovf=%b dz=%b want ea61 0 0",
               result, err_ovf, err_div0);
    end
    leave_done();
    accept(2'b10, 16'd300, 16'd200);
    wait_done(k);
    checks++;
    if (result !== 16'hEA60 || err_ovf !== 1'b1 || k != 18) begin
      errors++;
      $display("FAIL mul_ovf: res=%h ovf=%b k=%0d want ea60 1 18",
               result, err_ovf, k);
    end
    leave_done();
  endtask

  task automatic test_div();
    int k;
    accept(2'b11, -16'sd7, 16'd2);
    wait_done(k);
    checks++;
    if (result !== 16'hFFFD || err_ovf !== 1'b0 || err_div0 !== 1'b0 ||
        k != 18) begin
      errors++;
      $display("FAIL div_neg: res=%h ovf=%b dz=%b k=%0d want fffd 0 0 18",
               result, err_ovf, err_div0, k);
    end
    leave_done();
    accept(2'b11, 16'd5, 16'd0);
    wait_done(k);
    checks++;
    if (result !== 16'h0000 || err_ovf !== 1'b0 || err_div0 !== 1'b1 ||
        k != 2) begin
      errors++;
      $display("FAIL div_zero: res=%h ovf=%b dz=%b k=%0d want 0000 0 1 2",
               result, err_ovf, err_div0, k);
    end
    leave_done();
    accept(2'b11, 16'h8000, 16'hFFFF);
    wait_done(k);
    checks++;
    if (result !== 16'h8000 || err_ovf !== 1'b1 || err_div0 !== 1'b0) begin
      errors++;
      $display("FAIL div_min: res=%h ovf=%b dz=%b want 8000 1 0",
               result, err_ovf, err_div0);
    end
    leave_done();
  endtask

  task automatic test_sub_then_add();
    int k;
    accept(2'b01, 16'h8000, 16'h0001);
    wait_done(k);
    checks++;
    if (result !== 16'h7FFF || err_ovf !== 1'b1 || k != 2) begin
      errors++;
      $display("FAIL sub_ovf: res=%h ovf=%b k=%0d want 7fff 1 2",
               result, err_ovf, k);
    end
    leave_done();
    accept(2'b00, 16'd1, 16'd1);
    checks++;
    if (result !== 16'h0000 || err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL accept_clear: res=%h ovf=%b want 0000 0",
               result, err_ovf);
    end
    wait_done(k);
    checks++;
    if (result !== 16'd2 || err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_after: res=%h ovf=%b want 0002 0", result, err_ovf);
    end
    leave_done();
  endtask

  task automatic test_ignore_busy();
    int pulses;
    logic [15:0] got;
    accept(2'b10, 16'd3, 16'd4);
    repeat (3) @(posedge clock);
    @(negedge clock);
    op = 2'b00;
    operand_a = 16'd100;
    operand_b = 16'd100;
    execute = 1'b1;
    @(negedge clock);
    execute = 1'b0;
    pulses = 0;
    got = 'x;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        pulses++;
        got = result;
      end
    end
    checks++;
    if (pulses != 1 || got !== 16'd12) begin
      errors++;
      $display("FAIL ignore_busy: pulses=%0d res=%h want 1 000c",
               pulses, got);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int pulses;
    accept(2'b11, 16'd1000, 16'd7);
    repeat (5) @(posedge clock);
    #2;
    reset_in = 1'b1;
    #1;
    checks++;
    if ({busy, done, err_ovf, err_div0, result} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b ovf=%b dz=%b res=%h want 0",
               busy, done, err_ovf, err_div0, result);
    end
    @(negedge clock);
    reset_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_abandon: active cycles=%0d want 0", pulses);
    end
    accept(2'b00, 16'd2, 16'd3);
    wait_done(k);
    checks++;
    if (result !== 16'd5 || k != 2 || err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: res=%h k=%0d ovf=%b want 0005 2 0",
               result, k, err_ovf);
    end
    leave_done();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_sub_then_add();
    test_ignore_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
